// File: rtl/uart_vitals_rx.sv
// uart_vitals_rx: UART receiver, header/checksum frame parser and periodic publisher
// for N_CH one-byte vital-sign readings with stale flag and saturating error count.
module uart_vitals_rx #(
    parameter int         CLK_HZ  = 50_000_000,
    parameter int         BAUD    = 9600,
    parameter int         N_CH    = 2,
    parameter logic [7:0] HDR     = 8'hFF,
    parameter int         UPD_CYC = 50_000_000,
    parameter int         GAP_CYC = 3 * 10 * (CLK_HZ / BAUD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_rx,
    output logic [8*N_CH-1:0] vitals_o,
    output logic              upd_o,
    output logic              stale_o,
    output logic              frame_err_o,
    output logic [7:0]        err_cnt_o
);
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int BW = $clog2(BIT_CYC);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int PW = (UPD_CYC > 1) ? $clog2(UPD_CYC) : 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_DATA = 2'd1;
    localparam logic [1:0] P_CSUM = 2'd2;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              sync1, sync2, rx_prev;
    logic [2:0]        rx_state;
    logic [BW-1:0]     bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              byte_vld, stop_err;
    logic [1:0]        p_state;
    logic [IW-1:0]     idx;
    logic [7:0]        sum;
    logic [8*N_CH-1:0] buf_q, shadow;
    logic [GW-1:0]     gap_cnt;
    logic              fresh;
    logic [PW-1:0]     per_cnt;
    logic              timeout, csum_hit, csum_ok, csum_bad, err_evt, tc;

    assign timeout  = (p_state != P_HUNT) && !byte_vld && (gap_cnt == GW'(GAP_CYC - 1));
    assign csum_hit = byte_vld && (p_state == P_CSUM);
    assign csum_ok  = csum_hit && (shift == sum);
    assign csum_bad = csum_hit && (shift != sum);
    assign err_evt  = stop_err | timeout | csum_bad;
    assign tc       = (per_cnt == PW'(UPD_CYC - 1));

    // Serial receiver: start is confirmed at mid-bit, data/stop sampled one bit apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            sync1    <= data_rx;
            sync2    <= sync1;
            rx_prev  <= sync2;
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !sync2) begin
                        rx_state <= RX_START;
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt == BW'(HALF_CYC - 1)) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BW'(BIT_CYC - 1)) begin
                        bit_cnt <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BW'(BIT_CYC - 1)) begin
                        bit_cnt <= '0;
                        if (sync2) begin
                            byte_vld <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            stop_err <= 1'b1;
                            rx_state <= RX_WAIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (sync2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser: header, N_CH data bytes, mod-256 checksum; header bytes inside data are data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_HUNT;
            idx     <= '0;
            sum     <= '0;
            buf_q   <= '0;
            gap_cnt <= '0;
            shadow  <= '0;
        end else begin
            gap_cnt <= (p_state == P_HUNT || byte_vld) ? '0 : gap_cnt + 1'b1;
            if (csum_ok) shadow <= buf_q;
            if (stop_err || timeout) begin
                p_state <= P_HUNT;
            end else if (byte_vld) begin
                case (p_state)
                    P_HUNT: begin
                        if (shift == HDR) begin
                            p_state <= P_DATA;
                            idx     <= '0;
                            sum     <= '0;
                        end
                    end
                    P_DATA: begin
                        buf_q[8*int'(idx) +: 8] <= shift;
                        sum <= sum + shift;
                        if (idx == IW'(N_CH - 1)) p_state <= P_CSUM;
                        else                      idx     <= idx + 1'b1;
                    end
                    default: p_state <= P_HUNT;
                endcase
            end
        end
    end

    // Publish: a free-running period; a checksum pass on the terminal cycle waits one period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt     <= '0;
            vitals_o    <= '0;
            upd_o       <= 1'b0;
            stale_o     <= 1'b1;
            fresh       <= 1'b0;
            frame_err_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            per_cnt     <= tc ? '0 : per_cnt + 1'b1;
            upd_o       <= tc && fresh;
            frame_err_o <= err_evt;
            if (err_evt) err_cnt_o <= sat_inc(err_cnt_o);
            if (tc) begin
                if (fresh) vitals_o <= shadow;
                stale_o <= !fresh;
            end
            if (csum_ok) fresh <= 1'b1;
            else if (tc) fresh <= 1'b0;
        end
    end
endmodule
